serial_alu_acc: RTL and testbench

Bit-serial execution/write-back engine that consumes the LSB-first operand bit streams produced by the serial register file. It drives the register-file shift enable for one full word and computes one result bit per cycle, using a carry flip-flop for arithmetic. The result bits are deserialized into a parallel accumulator. When the word is complete, the block issues a single-cycle parallel store strobe back to the register file and updates the flags.

---
 rtl/serial_alu_acc_if.sv | 23 ++
 rtl/serial_alu_acc.sv | 72 +++++++
 tb/tb_serial_alu_acc.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/serial_alu_acc_if.sv
// serial_alu_acc_if: operand stream, control and result bundle between a bit-serial ALU and its register file.
interface serial_alu_acc_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       op;
  logic             rs1_bit;
  logic             rs2_bit;
  logic             shift_en;
  logic             result_bit;
  logic [WIDTH-1:0] acc_bits;
  logic             store_en;
  logic             busy;
  logic             done;
  logic             carry_flag;
  logic             zero_flag;
  modport master (
    output start, op, rs1_bit, rs2_bit,
    input  shift_en, result_bit, acc_bits, store_en, busy, done, carry_flag, zero_flag
  );
  modport slave (
    input  start, op, rs1_bit, rs2_bit,
    output shift_en, result_bit, acc_bits, store_en, busy, done, carry_flag, zero_flag
  );
endinterface

// File: rtl/serial_alu_acc.sv
// serial_alu_acc: bit-serial ALU that consumes LSB-first operand streams for one word,
// deserialises the result into an accumulator and issues a single store strobe.
module serial_alu_acc #(parameter int WIDTH = 8) (
  input logic            clk,
  input logic            rstn,
  serial_alu_acc_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, STORE} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic             r_cf, r_zf;
  logic             w_arith, w_b, w_sum, w_cy, w_res;
  always_comb begin
    w_arith = (r_op[2:1] == 2'b00);
    // SUB feeds ~b into the full adder with the carry preset to 1
    w_b     = bus.rs2_bit ^ (r_op == 3'd1);
    w_sum   = bus.rs1_bit ^ w_b ^ r_carry;
    w_cy    = (bus.rs1_bit & w_b) | (bus.rs1_bit & r_carry) | (w_b & r_carry);
    w_res   = 1'b0;
    case (r_op)
      3'd0, 3'd1: w_res = w_sum;
      3'd2:       w_res = bus.rs1_bit & bus.rs2_bit;
      3'd3:       w_res = bus.rs1_bit | bus.rs2_bit;
      3'd4:       w_res = bus.rs1_bit ^ bus.rs2_bit;
      3'd5:       w_res = bus.rs1_bit;
      3'd6:       w_res = bus.rs2_bit;
      default:    w_res = ~bus.rs1_bit;
    endcase
    w_next = (r_state == IDLE && bus.start)                ? RUN   :
             (r_state == RUN && r_cnt == CW'(WIDTH - 1))   ? STORE :
             (r_state == STORE)                            ? IDLE  : r_state;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_op    <= 3'd0;
      r_acc   <= '0;
      r_cf    <= 1'b0;
      r_zf    <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_op    <= bus.op;
        r_carry <= (bus.op == 3'd1);
        r_cnt   <= '0;
      end
      if (r_state == RUN) begin
        r_acc   <= {w_res, r_acc[WIDTH-1:1]};
        r_carry <= w_arith & w_cy;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (r_state == STORE) begin
        r_cf <= r_carry;
        r_zf <= (r_acc == '0);
      end
    end
  end
  assign bus.shift_en   = (r_state == RUN);
  assign bus.result_bit = (r_state == RUN) & w_res;
  assign bus.store_en   = (r_state == STORE);
  assign bus.done       = (r_state == STORE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.acc_bits   = r_acc;
  assign bus.carry_flag = r_cf;
  assign bus.zero_flag  = r_zf;
endmodule

// File: tb/tb_serial_alu_acc.sv
// tb_serial_alu_acc: randomized and directed operations checked every cycle against
// an arithmetic model of the whole-word result and the start-relative timeline.
module tb_serial_alu_acc;
  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   t_start = 0;
  int   k_c;
  int   errs = 0;
  int   checks = 0;
  bit   active = 1'b0;
  logic [8:0] m_res;
  logic [7:0] m_acc;
  logic       m_cf, m_zf;
  serial_alu_acc_if #(.WIDTH(8)) bus ();
  serial_alu_acc #(.WIDTH(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask
  function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 9'd1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a};
      3'd6:    return {1'b0, b};
      default: return {1'b0, ~a};
    endcase
  endfunction
  always @(negedge clk) begin
    k_c = cyc - t_start;
    if (!rstn) begin
      chk("rst_shift", bus.shift_en, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_store", bus.store_en, 0);
      chk("rst_acc", bus.acc_bits, 0);
      chk("rst_cf", bus.carry_flag, 0);
      chk("rst_zf", bus.zero_flag, 1);
    end else if (active && k_c < 8) begin
      chk("run_shift", bus.shift_en, 1);
      chk("run_busy", bus.busy, 1);
      chk("run_store", bus.store_en, 0);
      chk("run_done", bus.done, 0);
      chk("run_result_bit", bus.result_bit, m_res[k_c]);
    end else if (active && k_c == 8) begin
      chk("st_shift", bus.shift_en, 0);
      chk("st_busy", bus.busy, 1);
      chk("st_store", bus.store_en, 1);
      chk("st_done", bus.done, 1);
      chk("st_acc", bus.acc_bits, m_res[7:0]);
      m_acc  = m_res[7:0];
      m_cf   = m_res[8];
      m_zf   = (m_res[7:0] == 8'h00);
      active = 1'b0;
    end else begin
      chk("idle_shift", bus.shift_en, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_store", bus.store_en, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_result_bit", bus.result_bit, 0);
      chk("idle_acc", bus.acc_bits, m_acc);
      chk("idle_cf", bus.carry_flag, m_cf);
      chk("idle_zf", bus.zero_flag, m_zf);
    end
  end
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input bit lit, input logic [7:0] la, input logic lc, input logic lz);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    @(posedge clk);
    #1;
    t_start = cyc;
    m_res   = model(o, a, b);
    active  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rs1_bit = a[i];
      bus.rs2_bit = b[i];
      bus.start   = 1'($urandom_range(0, 1));
      bus.op      = 3'($urandom);
      @(posedge clk);
      #1;
    end
    bus.start   = 1'($urandom_range(0, 1));
    bus.rs1_bit = 1'($urandom);
    bus.rs2_bit = 1'($urandom);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (lit) begin
      chk("lit_model_acc", m_acc, la);
      chk("lit_acc", bus.acc_bits, la);
      chk("lit_cf", bus.carry_flag, lc);
      chk("lit_zf", bus.zero_flag, lz);
    end
  endtask
  task automatic abort_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    @(posedge clk);
    #1;
    t_start = cyc;
    m_res   = model(3'd0, a, b);
    active  = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rs1_bit = a[i];
      bus.rs2_bit = b[i];
      @(posedge clk);
      #1;
    end
    #1;
    active = 1'b0;
    m_acc  = 8'h00;
    m_cf   = 1'b0;
    m_zf   = 1'b1;
    rstn   = 1'b0;
    #1;
    chk("abort_shift", bus.shift_en, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_store", bus.store_en, 0);
    chk("abort_acc", bus.acc_bits, 0);
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask
  initial begin
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.rs1_bit = 1'b0;
    bus.rs2_bit = 1'b0;
    m_acc = 8'h00;
    m_cf = 1'b0;
    m_zf = 1'b1;
    m_res = '0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    do_op(3'd0, 8'h5A, 8'h33, 1, 8'h8D, 1'b0, 1'b0);
    do_op(3'd0, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1);
    do_op(3'd1, 8'h10, 8'h20, 1, 8'hF0, 1'b0, 1'b0);
    do_op(3'd1, 8'h20, 8'h10, 1, 8'h10, 1'b1, 1'b0);
    do_op(3'd4, 8'hAA, 8'hAA, 1, 8'h00, 1'b0, 1'b1);
    do_op(3'd7, 8'h0F, 8'h5C, 1, 8'hF0, 1'b0, 1'b0);
    abort_op(8'hFF, 8'h01);
    do_op(3'd0, 8'h01, 8'h01, 1, 8'h02, 1'b0, 1'b0);
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0, 8'h00, 1'b0, 1'b0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
